toggle_pulse_ctrl: RTL and testbench
====================================

Name: toggle_pulse_ctrl

Overview:
Upstream control stage for the T-flip-flop counter chain. Generates single-cycle toggle pulses (`tick`) that advance the chain.
- Run mode: ticks at a programmable divided rate.
- Single-step mode: one tick per request.
- Bounded-run mode: stops automatically after a programmed number of ticks.
- Also keeps a shadow count of ticks issued, for software/monitor use.

Parameters:
DIV_W, 8, width of prescaler divide value
CNT_W, 4, width of tick counter and limit (matches number of T_FF stages driven)

Ports:
clk  input  1  system clock, all state updated on rising edge
reset  input  1  asynchronous, active-low reset; all state cleared while low
start  input  1  begin continuous/bounded run (level sampled each clk)
stop  input  1  abort run, return to IDLE
step  input  1  request one tick when idle
div  input  DIV_W  prescaler value; tick period = div+1 clocks; latched on start
limit  input  CNT_W  ticks to issue in a run; 0 = free-run; latched on start
tick  output  1  one-cycle toggle pulse to counter chain
busy  output  1  high in RUN or STEP state
done  output  1  one-cycle pulse when a bounded run completes
tick_count  output  CNT_W  ticks issued since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE; tick, busy, done=0; tick_count=0; prescaler=0; latched div/limit=0.
- States: IDLE, RUN, STEP. All outputs registered.
- Command priority when asserted together: stop > start > step.
- IDLE:
  - start=1 → RUN: latch div, limit; clear prescaler and run counter.
  - step=1 (start=0) → STEP.
  - otherwise remain.
- RUN:
  - Prescaler counts 0..div_l, then reloads to 0.
  - tick=1 in the cycle the prescaler equals div_l. First tick occurs div_l+1 cycles after the start edge. div_l=0 → tick every cycle.
  - Each tick: tick_count+1 and run_cnt+1.
  - If limit_l≠0 and the tick being issued is the limit_l-th: go to IDLE next cycle and assert done=1 for exactly that one cycle (the cycle after the last tick).
  - stop=1: go to IDLE next cycle. No tick in that cycle even if the prescaler matches. No done.
  - start while RUN: ignored; latched values unchanged.
- STEP:
  - tick=1 for exactly one cycle, tick_count+1, then go to IDLE.
  - stop in STEP: abort, no tick.
  - step held high: re-triggers only after one IDLE cycle, so the maximum tick rate in step mode is every 2 cycles.
- busy=1 in RUN and STEP.
- tick_count wraps 2^CNT_W−1 → 0 with no other effect. Run termination is based on the internal run counter, not tick_count.
- Changes to div/limit during RUN have no effect until the next start.
- reset asserted mid-run: immediate clear, no done pulse, no tick.

Optional Feature:
Macro TOGGLE_PULSE_CTRL_PAUSE_EN.
- Defined: adds input port `pause` (1 bit). In RUN with pause=1:
  - prescaler and run counter hold; no ticks; busy stays 1.
  - stop still aborts.
  - On pause release, counting resumes from the held prescaler value.
  - pause has no effect in IDLE or STEP.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
1. Reset: reset=0 for 3 cycles mid-run (div=2) → tick, busy, done, tick_count all 0 immediately; state IDLE after release.
2. div=3, limit=4, start pulse → ticks on cycles 4, 8, 12, 16 after start; done=1 on cycle 17; busy falls the same cycle; tick_count=4.
3. div=0, limit=0, start, run 20 cycles, stop → 20 consecutive ticks; tick_count wraps 15→0→4 (CNT_W=4); no tick in the stop cycle; no done.
4. Step pulses ×3 while idle → exactly 3 single-cycle ticks, busy high 1 cycle each, tick_count=3. Step held high 6 cycles → 3 ticks.
5. Simultaneous start+step+stop in IDLE → remains IDLE, no tick. start+step in IDLE → RUN. Change div from 1 to 5 during RUN → period stays 2.
6. (PAUSE_EN) div=1, limit=6; pause for 5 cycles after the 2nd tick → no ticks during pause; remaining 4 ticks every 2 cycles after release; done after the 6th.

Source files
------------

// File: rtl/toggle_pulse_ctrl.sv
// Toggle-pulse controller for the T-flip-flop counter chain: run, single-step and bounded-run ticks.
// Optional pause input is enabled by defining TOGGLE_PULSE_CTRL_PAUSE_EN.
module toggle_pulse_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] limit,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   tick_count_q, tick_count_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               match;
  logic               finish;
  logic               paused;

`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign match  = (presc_q == div_q);
  // The limit-th tick has already been issued; this cycle ends the run with done.
  assign finish = (limit_q != '0) && (run_cnt_q == limit_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      div_q        <= '0;
      limit_q      <= '0;
      run_cnt_q    <= '0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      limit_q      <= limit_d;
      run_cnt_q    <= run_cnt_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
        end else if (step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (stop || finish) begin
          state_d = StIdle;
        end
      end
      StStep:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    presc_d      = presc_q;
    div_d        = div_q;
    limit_d      = limit_q;
    run_cnt_d    = run_cnt_q;
    tick_count_d = tick_count_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (!stop && start) begin
          div_d     = div;
          limit_d   = limit;
          presc_d   = '0;
          run_cnt_d = '0;
        end
      end
      StRun: begin
        if (!stop && finish) begin
          done_d = 1'b1;
        end else if (!stop && !paused) begin
          if (match) begin
            tick_d       = 1'b1;
            presc_d      = '0;
            run_cnt_d    = run_cnt_q + CNT_W'(1);
            tick_count_d = tick_count_q + CNT_W'(1);
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      StStep: begin
        if (!stop) begin
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_toggle_pulse_ctrl.sv
// Scoreboard bench for toggle_pulse_ctrl: directed scenarios plus random commands against a
// cycle-level reference model. Pause scenarios run only with TOGGLE_PULSE_CTRL_PAUSE_EN.
module tb_toggle_pulse_ctrl;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, stop, step, pause;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] limit;
  logic             tick, busy, done;
  logic [CNT_W-1:0] tick_count;

  toggle_pulse_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .step       (step),
`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
    .pause      (pause),
`endif
    .div        (div),
    .limit      (limit),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: mode 0=idle 1=run 2=step; t counts active run cycles, n ticks in this run.
  int               m_mode = 0;
  int unsigned      m_t = 0, m_n = 0;
  int unsigned      m_div = 0, m_lim = 0, m_count = 0;

  // Inputs the next cycle() call applies at the falling edge.
  logic             nr = 1'b0, ns = 1'b0, np = 1'b0, nt = 1'b0, nz = 1'b0;
  logic [DIV_W-1:0] nd = '0;
  logic [CNT_W-1:0] nl = '0;

  function automatic exp_t model_edge();
    exp_t e;
    logic p;
    e = '0;
`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
    p = pause;
`else
    p = 1'b0;
`endif
    if (!reset) begin
      m_mode = 0; m_t = 0; m_n = 0; m_div = 0; m_lim = 0; m_count = 0;
    end else begin
      case (m_mode)
        0: begin
          if (stop) m_mode = 0;
          else if (start) begin
            m_mode = 1; m_div = div; m_lim = limit; m_t = 0; m_n = 0;
          end else if (step) m_mode = 2;
        end
        1: begin
          if (stop) m_mode = 0;
          else if (m_lim != 0 && m_n == m_lim) begin
            m_mode = 0; e.done = 1'b1;
          end else if (!p) begin
            if (m_t % (m_div + 1) == m_div) begin
              e.tick = 1'b1; m_n++; m_count = (m_count + 1) % (1 << CNT_W);
            end
            m_t++;
          end
        end
        default: begin
          if (!stop) begin
            e.tick = 1'b1; m_count = (m_count + 1) % (1 << CNT_W);
          end
          m_mode = 0;
        end
      endcase
    end
    e.busy = (m_mode != 0);
    e.cnt  = CNT_W'(m_count);
    return e;
  endfunction

  task automatic cycle();
    logic was_rst;
    @(negedge clk);
    was_rst = reset;
    reset = ~nr; start = ns; stop = np; step = nt; pause = nz; div = nd; limit = nl;
    q.push_back(model_edge());
    if (was_rst && !reset) begin
      #1;
      checks++;
      if ({tick, busy, done, tick_count} !== '0)
        $display("FAIL async_reset_clear got=%b want=0", {tick, busy, done, tick_count});
      else passes++;
    end
  endtask

  task automatic idle(input int k);
    ns = 0; np = 0; nt = 0; nz = 0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic cmd(input logic s_start, input logic s_stop, input logic s_step);
    ns = s_start; np = s_stop; nt = s_step;
    cycle();
    ns = 0; np = 0; nt = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({tick, busy, done, tick_count} !== e)
          $display("FAIL outputs t=%0t got tick=%b busy=%b done=%b cnt=%0d want tick=%b busy=%b done=%b cnt=%0d",
                   $time, tick, busy, done, tick_count, e.tick, e.busy, e.done, e.cnt);
        else passes++;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; start = 0; stop = 0; step = 0; pause = 0; div = '0; limit = '0;
    nr = 1; idle(3); nr = 0; idle(2);

    // Reset mid-run
    nd = 2; nl = 0; cmd(1, 0, 0); idle(7);
    nr = 1; idle(3); nr = 0; idle(3);

    // Bounded run: div=3, limit=4
    nd = 3; nl = 4; cmd(1, 0, 0); idle(20);

    // Free run at full rate with wrap, then stop
    nr = 1; idle(1); nr = 0;
    nd = 0; nl = 0; cmd(1, 0, 0); idle(19); cmd(0, 1, 0); idle(3);

    // Step pulses, then step held
    for (int i = 0; i < 3; i++) begin cmd(0, 0, 1); idle(2); end
    nt = 1; for (int i = 0; i < 6; i++) cycle(); nt = 0; idle(3);

    // Priority and latched div
    cmd(1, 1, 1); idle(2);
    nd = 1; cmd(1, 0, 1); idle(2); nd = 5; idle(8); cmd(1, 0, 0); idle(3); cmd(0, 1, 0); idle(2);

`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
    nd = 1; nl = 6; cmd(1, 0, 0); idle(4);
    nz = 1; for (int i = 0; i < 5; i++) cycle(); nz = 0; idle(12);
`endif

    // Random commands
    for (int i = 0; i < 3000; i++) begin
      nr = ($urandom_range(0, 199) == 0);
      ns = ($urandom_range(0, 9) == 0);
      np = ($urandom_range(0, 29) == 0);
      nt = ($urandom_range(0, 9) == 0);
`ifdef TOGGLE_PULSE_CTRL_PAUSE_EN
      nz = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 3) == 0) nd = DIV_W'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) nl = CNT_W'($urandom_range(0, 6));
      cycle();
    end
    nr = 0; idle(4);
    @(posedge clk); #2;

    checks++;
    if (q.size() != 0) $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
